// File: rtl/smg_pkg.sv
// Shared types and constants for the 74HC595-style serial frame receiver.
// Holds the FSM state type and the active-low 7-segment pattern table.
package smg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Returns {bad, hex}; an unrecognized pattern yields {1'b1, 4'hF}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'h1F;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                res = {1'b0, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/smg_sync_edge.sv
// Two-flop synchronizer with a history flop and a registered rising-edge pulse.
// Level and pulse leave with equal latency so data stays aligned with its clock.
module smg_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1_q, s2_q, hist_q, rise_q;
    logic v1_q, v2_q, seen_low_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            hist_q     <= 1'b0;
            rise_q     <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            hist_q <= s2_q;
            v1_q   <= 1'b1;
            v2_q   <= v1_q;
            // A pin held high across reset must first be seen low before any edge counts.
            if (v2_q && !s2_q) begin
                seen_low_q <= 1'b1;
            end
            rise_q <= s2_q & ~hist_q & seen_low_q;
        end
    end

    assign level = hist_q;
    assign rise  = rise_q;

endmodule

// File: rtl/smg_595_rx.sv
// Receives frames shifted out by a 74HC595 driver and presents them in parallel.
// Define SMG_595_RX_DECODE_EN to add registered 7-segment digit decode outputs.
module smg_595_rx
    import smg_pkg::*;
#(
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ds_data,
    input  logic                  ds_shcp,
    input  logic                  ds_stcp,
    output logic [FRAME_BITS-1:0] q,
    output logic                  frame_vld,
    output logic                  frame_err,
    output logic [7:0]            bit_cnt
`ifdef SMG_595_RX_DECODE_EN
    ,
    output logic [3:0]            digit_hex,
    output logic                  digit_bad,
    output logic [7:0]            digit_sel
`endif
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic data_level, data_rise;
    logic shcp_level, shcp_rise;
    logic stcp_level, stcp_rise;
    logic unused_sync;

    smg_sync_edge u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ds_data),
        .level (data_level),
        .rise  (data_rise)
    );

    smg_sync_edge u_sync_shcp (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ds_shcp),
        .level (shcp_level),
        .rise  (shcp_rise)
    );

    smg_sync_edge u_sync_stcp (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ds_stcp),
        .level (stcp_level),
        .rise  (stcp_rise)
    );

    assign unused_sync = ^{data_rise, shcp_level, stcp_level};

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [FRAME_BITS-1:0] q_q, q_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  vld_q, vld_d;
    logic                  err_q, err_d;
    logic                  timeout;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        timeout = (state_q == SHIFT) && !shcp_rise && !stcp_rise &&
                  (idle_q == IDLE_W'(TIMEOUT - 1));

        case (state_q)
            IDLE:    if (shcp_rise) state_d = SHIFT;
            SHIFT:   if ((stcp_rise && !shcp_rise) || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Latch captures the pre-shift register even when a shift lands in the same cycle.
        if (stcp_rise) begin
            q_d   = sr_q;
            vld_d = 1'b1;
            err_d = ({24'd0, cnt_q} != FRAME_BITS);
            cnt_d = 8'd0;
        end

        if (shcp_rise) begin
            sr_d  = {sr_q[FRAME_BITS-2:0], data_level};
            cnt_d = stcp_rise ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
        end

        if (timeout) begin
            err_d = 1'b1;
            cnt_d = 8'd0;
        end

        idle_d = (state_d == SHIFT && !shcp_rise) ? idle_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            q_q     <= '0;
            cnt_q   <= 8'd0;
            idle_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign q         = q_q;
    assign frame_vld = vld_q;
    assign frame_err = err_q;
    assign bit_cnt   = cnt_q;

`ifdef SMG_595_RX_DECODE_EN
    logic [3:0] hex_q;
    logic       bad_q;
    logic [7:0] sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q <= 4'd0;
            bad_q <= 1'b0;
            sel_q <= 8'd0;
        end else if (stcp_rise) begin
            {bad_q, hex_q} <= seg_decode(sr_q[6:0]);
            sel_q          <= sr_q[15:8];
        end
    end

    assign digit_hex = hex_q;
    assign digit_bad = bad_q;
    assign digit_sel = sel_q;
`endif

endmodule

// File: tb/tb_smg_595_rx.sv
// Directed plus randomized bench for smg_595_rx against a bit-stream reference model.
module tb_smg_595_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ds_data = 1'b0;
    logic        ds_shcp = 1'b0;
    logic        ds_stcp = 1'b0;
    logic [15:0] q;
    logic        frame_vld, frame_err;
    logic [7:0]  bit_cnt;
`ifdef SMG_595_RX_DECODE_EN
    logic [3:0]  digit_hex;
    logic        digit_bad;
    logic [7:0]  digit_sel;
`endif

    smg_595_rx #(.FRAME_BITS(16), .TIMEOUT(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ds_data   (ds_data),
        .ds_shcp   (ds_shcp),
        .ds_stcp   (ds_stcp),
        .q         (q),
        .frame_vld (frame_vld),
        .frame_err (frame_err),
        .bit_cnt   (bit_cnt)
`ifdef SMG_595_RX_DECODE_EN
        ,
        .digit_hex (digit_hex),
        .digit_bad (digit_bad),
        .digit_sel (digit_sel)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vld_cnt = 0, err_cnt = 0, vld_cyc = 0, err_cyc = 0;
    always @(negedge clk) begin
        if (frame_vld === 1'b1) begin
            vld_cnt <= vld_cnt + 1;
            vld_cyc <= cyc;
        end
        if (frame_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    // Reference model: every bit shifted since reset, and bits since the last latch/abandon.
    bit          stream[$];
    int          nbits = 0;
    logic [15:0] exp_q = 16'h0;
    int          exp_vld = 0, exp_err = 0;
    int          last_rise = 0, stcp_cyc = 0;
    int          checks = 0, errors = 0;

    logic [7:0] seg_ref [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [15:0] last16();
        logic [15:0] v;
        v = 16'h0;
        for (int i = 0; i < stream.size(); i++) v = {v[14:0], stream[i]};
        return v;
    endfunction

    function automatic logic [4:0] ref_decode(input logic [7:0] v);
        logic [4:0] r;
        r = 5'h1F;
        for (int i = 0; i < 16; i++) begin
            if (v[6:0] == seg_ref[i][6:0]) r = {1'b0, 4'(i)};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input bit b, input int lo, input int hi);
        ds_data = b;
        ds_shcp = 1'b0;
        tick(lo);
        ds_shcp = 1'b1;
        last_rise = cyc;
        tick(hi);
        stream.push_back(b);
        nbits = (nbits < 255) ? nbits + 1 : 255;
    endtask

    task automatic shift_word(input logic [15:0] w, input int hi_idx, input int lo_idx,
                              input bit rnd);
        for (int i = hi_idx; i >= lo_idx; i--) begin
            if (rnd) shift_bit(w[i], $urandom_range(2, 6), $urandom_range(2, 6));
            else shift_bit(w[i], 10, 10);
        end
    endtask

    task automatic latch();
        ds_shcp = 1'b0;
        tick(2);
        ds_stcp = 1'b1;
        stcp_cyc = cyc;
        tick(3);
        ds_stcp = 1'b0;
        tick(8);
        exp_q = last16();
        exp_vld++;
        if (nbits != 16) exp_err++;
        nbits = 0;
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_q"}, 32'(q), 32'(exp_q));
        check({tag, "_bit_cnt"}, 32'(bit_cnt), 32'(nbits));
        check({tag, "_vld_count"}, vld_cnt, exp_vld);
        check({tag, "_err_count"}, err_cnt, exp_err);
`ifdef SMG_595_RX_DECODE_EN
        check({tag, "_digit"}, {27'd0, digit_bad, digit_hex}, 32'(ref_decode(exp_q[7:0])));
        check({tag, "_sel"}, 32'(digit_sel), 32'(exp_q[15:8]));
`endif
    endtask

    initial begin
        logic [15:0] w;
        int          k, d, err0;

        // Reset state.
        tick(3);
        check("rst_q", 32'(q), 32'h0);
        check("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        check("rst_vld", 32'(frame_vld), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Full frame, slow shift clock, with exact latch latency.
        shift_word(16'hA5C3, 15, 0, 1'b0);
        check("a5c3_mid_bit_cnt", 32'(bit_cnt), 32'd16);
        latch();
        check_frame("a5c3");
        check("stcp_latency", vld_cyc - stcp_cyc, 32'd4);

        // Short frame: old low nibble moves up, vld and err together.
        w = 16'($urandom);
        shift_word(w, 11, 0, 1'b1);
        latch();
        check_frame("short12");
        check("short12_err_with_vld", err_cyc, vld_cyc);

        // Randomized frames and timings.
        for (int n = 0; n < 6; n++) begin
            w = 16'($urandom);
            k = $urandom_range(1, 15);
            shift_word(w, 15, 16 - k, 1'b1);
            tick(4);
            check("rnd_mid_bit_cnt", 32'(bit_cnt), 32'(k));
            shift_word(w, 15 - k, 0, 1'b1);
            latch();
            check_frame("rnd");
        end

        // Timeout abandons the partial frame without touching q.
        w = 16'($urandom);
        shift_word(w, 4, 0, 1'b1);
        ds_shcp = 1'b0;
        err0 = err_cnt;
        tick(150);
        d = err_cyc - last_rise;
        check("timeout_err_count", err_cnt - err0, 32'd1);
        check("timeout_window", 32'((d >= 100) && (d <= 106)), 32'd1);
        exp_err++;
        nbits = 0;
        check_frame("timeout");

        // Latch while idle re-latches the retained shift register and flags an error.
        latch();
        check_frame("idle_latch");

        // Shift and latch edges in the same cycle.
        w = 16'($urandom);
        shift_word(w, 15, 0, 1'b1);
        ds_data = ~w[0];
        ds_shcp = 1'b0;
        tick(3);
        ds_shcp = 1'b1;
        ds_stcp = 1'b1;
        tick(3);
        ds_shcp = 1'b0;
        ds_stcp = 1'b0;
        tick(8);
        exp_q = last16();
        exp_vld++;
        stream.push_back(~w[0]);
        nbits = 1;
        check_frame("simul");
        w = 16'($urandom);
        shift_word(w, 14, 0, 1'b1);
        latch();
        check_frame("simul_follow");

        // Reset mid-frame with the shift clock held high through release.
        w = 16'($urandom);
        shift_word(w, 7, 0, 1'b1);
        rst_n = 1'b0;
        tick(3);
        stream.delete();
        nbits = 0;
        exp_q = 16'h0;
        check("midrst_q", 32'(q), 32'h0);
        check("midrst_bit_cnt", 32'(bit_cnt), 32'h0);
        rst_n = 1'b1;
        tick(10);
        check("post_rst_no_edge", 32'(bit_cnt), 32'h0);
        shift_word(16'h01C0, 15, 0, 1'b1);
        latch();
        check_frame("f01c0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
